// File: rtl/reg_file_param.sv
// Parametrised 2R/1W integer register file with a hardware clear sequencer,
// dropped-write reporting and optional write-to-read bypass (REGFILE_BYPASS_EN).
module reg_file_param #(
  parameter  int XLEN     = 64,
  parameter  int NREG     = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_req,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            ready,
  output logic            wr_drop
);

  localparam bit            ZR        = (ZERO_REG != 0);
  localparam logic [AW-1:0] FIRST_PTR = ZR ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST_PTR  = AW'(NREG - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e                       state_q, state_d;
  logic [AW-1:0]                clr_ptr_q, clr_ptr_d;
  logic                         wr_drop_q, wr_drop_d;
  logic [NREG-1:0][XLEN-1:0]    regs_q, regs_d;
  logic                         wr_ok, wr_zero;

  assign wr_ok   = (state_q == RUN) && we && !clear_req;
  assign wr_zero = ZR && (waddr == '0);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    regs_d    = regs_q;
    case (state_q)
      INIT: begin
        regs_d[clr_ptr_q] = '0;
        if (clr_ptr_q == LAST_PTR) state_d = RUN;
        else                       clr_ptr_d = clr_ptr_q + AW'(1);
      end
      default: begin
        if (wr_ok && !wr_zero) regs_d[waddr] = wdata;
      end
    endcase
    // A clear request wins over both the sweep and any pending write.
    if (clear_req) begin
      state_d   = INIT;
      clr_ptr_d = FIRST_PTR;
    end
    wr_drop_d = we && ((state_q == INIT) || clear_req);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT;
      clr_ptr_q <= FIRST_PTR;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage is deliberately not reset; the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (state_q == RUN) begin
      if (!(ZR && raddr1 == '0)) rdata1 = regs_q[raddr1];
      if (!(ZR && raddr2 == '0)) rdata2 = regs_q[raddr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && !wr_zero && waddr == raddr1) rdata1 = wdata;
      if (wr_ok && !wr_zero && waddr == raddr2) rdata2 = wdata;
`endif
    end
  end

  assign ready   = (state_q == RUN);
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (x0 hardwired / ordinary) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rd1 [2];
  logic [63:0] rd2 [2];
  logic        rdy [2];
  logic        drp [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_param #(.XLEN(64), .NREG(32), .ZERO_REG(1)) u_z1 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]),
    .rdata2(rd2[0]), .ready(rdy[0]), .wr_drop(drp[0]));

  reg_file_param #(.XLEN(64), .NREG(32), .ZERO_REG(0)) u_z0 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]),
    .rdata2(rd2[1]), .ready(rdy[1]), .wr_drop(drp[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a count of clear cycles still owed; when it reaches zero the whole
  // file is zero. Reads in the clear window are zero, so exact sweep order is
  // unobservable and not modelled.
  int          left [2];
  logic [63:0] mem [2][32];
  logic        mdrop [2];
  int          first [2] = '{1, 0};

  initial for (int k = 0; k < 2; k++) for (int j = 0; j < 32; j++) mem[k][j] = '0;

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        left[k]  = 32 - first[k];
        mdrop[k] = 1'b0;
      end else begin
        mdrop[k] = we && (left[k] != 0 || clear_req);
        if (clear_req) left[k] = 32 - first[k];
        else if (left[k] != 0) begin
          left[k]--;
          if (left[k] == 0) for (int j = 0; j < 32; j++) mem[k][j] = '0;
        end else if (we && !(first[k] == 1 && waddr == 0)) mem[k][waddr] = wdata;
      end
    end
  end

  function automatic logic [63:0] exp_rd(input int k, input logic [4:0] a);
    logic [63:0] v;
    v = (left[k] != 0 || (first[k] == 1 && a == 0)) ? 64'd0 : mem[k][a];
`ifdef REGFILE_BYPASS_EN
    if (left[k] == 0 && we && !clear_req && waddr == a && !(first[k] == 1 && waddr == 0))
      v = wdata;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rdata1_i%0d", k), rd1[k], exp_rd(k, raddr1));
      chk($sformatf("rdata2_i%0d", k), rd2[k], exp_rd(k, raddr2));
      chk($sformatf("ready_i%0d", k), 64'(rdy[k]), 64'(left[k] == 0));
      chk($sformatf("wr_drop_i%0d", k), 64'(drp[k]), 64'(mdrop[k]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k, output int n);
    n = 0;
    while (!rdy[k] && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("ready_timeout", 64'(n), 64'd0);
  endtask

  int n;

  initial begin
    // 1. reset and initial clear sweep
    #1 reset = 1'b0;
    raddr1 = 5'd3;
    raddr2 = 5'd31;
    repeat (3) step();
    reset = 1'b1;
    chk("init_rd_zero", rd1[0], 64'd0);
    wait_ready(0, n);
    chk("init_len_z1", 64'(n), 64'd31);
    chk("z0_not_ready_yet", 64'(rdy[1]), 64'd0);
    step();
    chk("z0_ready_32", 64'(rdy[1]), 64'd1);
    chk("run_rd_zero", rd2[1], 64'd0);

    // 2. write then read on both ports
    we = 1'b1; waddr = 5'd5; wdata = 64'h0000_0000_DEAD_BEEF;
    step();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    chk("rd1_reg5", rd1[0], 64'h0000_0000_DEAD_BEEF);
    chk("rd2_reg5", rd2[0], 64'h0000_0000_DEAD_BEEF);
    chk("rd1_reg5_z0", rd1[1], 64'h0000_0000_DEAD_BEEF);

    // 3. x0 behaviour
    we = 1'b1; waddr = 5'd0; wdata = 64'h1234;
    step();
    we = 1'b0; raddr1 = 5'd0;
    #1;
    chk("x0_zero", rd1[0], 64'd0);
    chk("x0_no_drop", 64'(drp[0]), 64'd0);
    chk("r0_plain", rd1[1], 64'h1234);

    // 4a. write during the clear sweep is dropped
    clear_req = 1'b1;
    step();
    clear_req = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 64'd1;
    step();
    we = 1'b0;
    chk("drop_init_z1", 64'(drp[0]), 64'd1);
    chk("drop_init_z0", 64'(drp[1]), 64'd1);
    step();
    chk("drop_pulse_end", 64'(drp[0]), 64'd0);
    wait_ready(1, n);

    // 4b. write colliding with clear
    we = 1'b1; waddr = 5'd7; wdata = 64'hAA;
    step();
    wdata = 64'hBB; clear_req = 1'b1;
    step();
    we = 1'b0; clear_req = 1'b0; raddr1 = 5'd7;
    chk("drop_clear", 64'(drp[0]), 64'd1);
    chk("ready_fell", 64'(rdy[0]), 64'd0);
    wait_ready(0, n);
    chk("clear_len", 64'(n), 64'd31);
    chk("reg7_cleared", rd1[0], 64'd0);
    step();

    // 5. same-cycle read of the register being written
    raddr1 = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 64'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", rd1[0], 64'h55);
`else
    chk("no_bypass_old", rd1[0], 64'd0);
`endif
    step();
    we = 1'b0;
    #1;
    chk("reg9_next", rd1[0], 64'h55);

    // 6. reset in the middle of the sweep (pointer at 10)
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    wait_ready(0, n);
    chk("mid_reset_len", 64'(n), 64'd31);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised integer register file for the RISC-V datapath.
- Generalises the fixed 32x64 two-read/one-write file with:
  - configurable width and depth;
  - optional hardwired-zero x0;
  - a hardware clear sequencer with a ready handshake;
  - dropped-write reporting;
  - optional write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- XLEN, 64, data width of each register in bits.
- NREG, 32, number of registers; power of two, at least 4. Address width AW = clog2(NREG), derived.
- ZERO_REG, 1:
  - 1 = register 0 reads as zero and ignores writes;
  - 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- clear_req  input  1  synchronous request to re-zero all registers.
- we  input  1  write enable.
- waddr  input  AW  write register index.
- wdata  input  XLEN  write data.
- raddr1  input  AW  read port 1 index.
- raddr2  input  AW  read port 2 index.
- rdata1  output  XLEN  read port 1 data (combinational).
- rdata2  output  XLEN  read port 2 data (combinational).
- ready  output  1  1 = file usable; 0 = clear sequence in progress.
- wr_drop  output  1  registered one-cycle pulse: a requested write was discarded.

Behaviour:
- FSM states: INIT, RUN. Clear pointer clr_ptr is AW bits wide. FIRST = 1 if ZERO_REG, else 0.
- reset low (async): state = INIT, clr_ptr = FIRST, wr_drop = 0, ready = 0. The array is not cleared by reset itself.
- INIT, each clock:
  - register[clr_ptr] <= 0;
  - if clr_ptr == NREG-1, go to RUN; else clr_ptr + 1.
  - Duration is NREG-FIRST cycles after reset release (31 cycles at the defaults).
- RUN:
  - ready = 1;
  - if we and not clear_req: register[waddr] <= wdata at the rising edge;
  - if ZERO_REG and waddr == 0, the write is silently ignored; this is not a drop.
- clear_req in RUN: next state INIT, clr_ptr = FIRST, ready falls the next cycle.
- clear_req in INIT: restarts the sequence, clr_ptr = FIRST.
- wr_drop is set the cycle after any edge where we = 1 and the write is not performed because:
  - state is INIT, or
  - we and clear_req are asserted together (clear has priority).
  - Otherwise wr_drop = 0.
- Reads:
  - rdataN = register[raddrN] in RUN;
  - rdataN = 0 in INIT;
  - rdataN = 0 whenever ZERO_REG and raddrN == 0.
- Both read ports are independent and may use the same address.
- Reset asserted mid-INIT or mid-RUN: immediate return to INIT with pointer reset. Register contents hold until overwritten by the sequence.
- Reads are combinational, with no added latency. Writes become visible on the next cycle without bypass.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read bypass. rdataN = wdata in the same cycle when all of these hold:
  - state is RUN;
  - we = 1 and clear_req = 0;
  - waddr == raddrN;
  - not (ZERO_REG and waddr == 0).
- Not defined: rdataN shows the pre-write array value during the write cycle.
- The FSM, wr_drop and ready are identical in both builds.

Test Plan:
1. Reset sequence: hold reset = 0 for 3 cycles, release. ready = 0 for exactly 31 rising edges, then 1. Every raddr reads 0.
2. Write/read: in RUN, write 64'h0000_0000_DEAD_BEEF to reg 5. Next cycle raddr1 = 5 gives that value. raddr2 = 5 gives the same value simultaneously.
3. x0 (ZERO_REG = 1): write 64'h1234 to reg 0. raddr1 = 0 reads 0 and wr_drop stays 0. Repeat with ZERO_REG = 0: reg 0 reads 64'h1234, and ready rises after 32 cycles.
4. Drops and clear:
   - write during INIT gives a wr_drop pulse on the next cycle;
   - in RUN, assert we with reg 7 = 64'hAA together with clear_req. wr_drop pulses, ready falls, and reg 7 reads 0 after ready returns (31 cycles later).
5. Bypass:
   - with REGFILE_BYPASS_EN: raddr1 = waddr = 9 and wdata = 64'h55 gives rdata1 = 64'h55 in the same cycle;
   - without it, rdata1 shows the old value (0) that cycle and 64'h55 the next.
6. Mid-operation reset: assert reset at clr_ptr = 10 during INIT. After release, ready rises exactly 31 cycles later.
